// File: rtl/fb_bus_arbiter.sv
// fb_bus_arbiter: shares one Avalon-MM SDRAM master between VGA scan-out and the draw engine
//   clk, reset (async, active-low)
//   vga_*  : read-only VGA port (read, address, waitrequest, readdatavalid, readdata)
//   drw_*  : draw port (read, write, address, writedata, byteenable, waitrequest, readdatavalid, readdata)
//   mem_*  : SDRAM controller master (read, write, address, writedata, byteenable, waitrequest,
//            readdatavalid, readdata)
module fb_bus_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int MAX_PENDING = 8,
  parameter int VGA_BURST   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_read,
  input  logic [ADDR_W-1:0] vga_address,
  output logic              vga_waitrequest,
  output logic              vga_readdatavalid,
  output logic [31:0]       vga_readdata,
  input  logic              drw_read,
  input  logic              drw_write,
  input  logic [ADDR_W-1:0] drw_address,
  input  logic [31:0]       drw_writedata,
  input  logic [3:0]        drw_byteenable,
  output logic              drw_waitrequest,
  output logic              drw_readdatavalid,
  output logic [31:0]       drw_readdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [31:0]       mem_readdata
);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = $clog2(VGA_BURST + 1);
  localparam logic [PW:0]   FULL = (PW+1)'(MAX_PENDING);
  localparam logic [CW-1:0] BMAX = CW'(VGA_BURST);
  typedef enum logic [1:0] {IDLE, VGA, DRW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [MAX_PENDING-1:0] tag_mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] occ;
  logic gv, gd, drw_req, cmd_rd, blk, acc, own_req, push, pop, head;
  assign drw_req = drw_read | drw_write;
  assign gv = state == VGA;
  assign gd = state == DRW;
  assign cmd_rd = gv ? vga_read : gd & drw_read;
  // a read with no free tag slot is held off; writes carry no tag and always pass
  assign blk = cmd_rd & (occ == FULL);
  assign mem_read = cmd_rd & ~blk;
  assign mem_write = gd & drw_write;
  assign mem_address = gd ? drw_address : gv ? vga_address : '0;
  assign mem_writedata = gd ? drw_writedata : '0;
  assign mem_byteenable = gd ? drw_byteenable : gv ? 4'hF : 4'h0;
  assign vga_waitrequest = ~gv | mem_waitrequest | blk;
  assign drw_waitrequest = ~gd | mem_waitrequest | blk;
  assign acc = (mem_read | mem_write) & ~mem_waitrequest;
  assign push = mem_read & ~mem_waitrequest;
  // returns with nothing outstanding are dropped
  assign pop = mem_readdatavalid & (occ != '0);
  assign head = tag_mem[rd_ptr];
  assign vga_readdatavalid = pop & ~head;
  assign drw_readdatavalid = pop & head;
  assign vga_readdata = mem_readdata;
  assign drw_readdata = mem_readdata;
  assign own_req = gv ? vga_read : gd & drw_req;
  // cnt_n counts VGA commands accepted in this burst including this cycle, so draw
  // gets the bus right after the VGA_BURST-th accept
  assign cnt_n = (~drw_req | (gd & acc)) ? '0 : (gv & acc & (cnt != BMAX)) ? cnt + 1'b1 : cnt;
  assign state_n = (state == IDLE || !own_req || acc)
                 ? ((vga_read && (cnt_n < BMAX || !drw_req)) ? VGA : drw_req ? DRW : IDLE)
                 : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (push) begin
        tag_mem[wr_ptr] <= gd;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  a_orphan_return: assert property (@(posedge clk) disable iff (!reset) !(mem_readdatavalid && occ == '0))
    else $warning("fb_bus_arbiter: readdatavalid with no read outstanding was dropped");
endmodule

// File: tb/tb_fb_bus_arbiter.sv
// tb_fb_bus_arbiter: scoreboard bench for fb_bus_arbiter against a transaction-level model
module tb_fb_bus_arbiter;
  localparam int AW = 26, MAXP = 8, VB = 16, LAT = 3;
  logic clk = 0, reset = 0;
  logic vga_read = 0;
  logic [AW-1:0] vga_address = '0;
  logic vga_waitrequest, vga_readdatavalid;
  logic [31:0] vga_readdata;
  logic drw_read = 0, drw_write = 0;
  logic [AW-1:0] drw_address = '0;
  logic [31:0] drw_writedata = '0;
  logic [3:0] drw_byteenable = '0;
  logic drw_waitrequest, drw_readdatavalid;
  logic [31:0] drw_readdata;
  logic mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0] mem_byteenable;
  logic mem_waitrequest = 0, mem_readdatavalid = 0;
  logic [31:0] mem_readdata = '0;
  always #5 clk = ~clk;
  fb_bus_arbiter #(.ADDR_W(AW), .MAX_PENDING(MAXP), .VGA_BURST(VB)) dut (
    .clk(clk), .reset(reset),
    .vga_read(vga_read), .vga_address(vga_address), .vga_waitrequest(vga_waitrequest),
    .vga_readdatavalid(vga_readdatavalid), .vga_readdata(vga_readdata),
    .drw_read(drw_read), .drw_write(drw_write), .drw_address(drw_address),
    .drw_writedata(drw_writedata), .drw_byteenable(drw_byteenable),
    .drw_waitrequest(drw_waitrequest), .drw_readdatavalid(drw_readdatavalid),
    .drw_readdata(drw_readdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata(mem_readdata)
  );
  typedef struct {int due; logic [31:0] data;} ret_t;
  typedef struct {bit port; logic [31:0] data;} exp_t;
  ret_t mem_pend[$];
  exp_t exp_q[$];
  bit tags[$];
  int owner, cnt, cyc, checks, errors, vga_v, drw_v;
  bit ret_en, last_acc, last_vacc, last_dacc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  // one bus cycle: inputs are already set; model predicts, DUT is compared at negedge
  task automatic tick();
    bit drq, gv, gd, rd, wr, blk, erd, acc, oreq;
    int cn;
    ret_t r;
    exp_t e;
    drq = drw_read | drw_write;
    gv = owner == 1;
    gd = owner == 2;
    rd = gv ? vga_read : (gd & drw_read);
    wr = gd & drw_write;
    blk = rd && tags.size() == MAXP;
    erd = rd & !blk;
    acc = (erd | wr) & !mem_waitrequest;
    mem_readdatavalid = 0;
    mem_readdata = '0;
    if (ret_en && mem_pend.size() > 0 && mem_pend[0].due <= cyc) begin
      r = mem_pend.pop_front();
      mem_readdatavalid = 1;
      mem_readdata = r.data;
      if (tags.size() > 0) begin
        e.port = tags.pop_front();
        e.data = r.data;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    chk("mem_read", 32'(mem_read), 32'(erd));
    chk("mem_write", 32'(mem_write), 32'(wr));
    chk("vga_wait", 32'(vga_waitrequest), 32'(!gv | mem_waitrequest | blk));
    chk("drw_wait", 32'(drw_waitrequest), 32'(!gd | mem_waitrequest | blk));
    if (erd | wr) begin
      chk("mem_addr", 32'(mem_address), gd ? 32'(drw_address) : 32'(vga_address));
      chk("mem_be", 32'(mem_byteenable), gd ? 32'(drw_byteenable) : 32'hF);
      chk("mem_wdata", mem_writedata, gd ? drw_writedata : 32'h0);
    end
    last_vacc = vga_read & !vga_waitrequest;
    last_dacc = (drw_read | drw_write) & !drw_waitrequest;
    cn = (!drq || (gd && acc)) ? 0 : (gv && acc && cnt < VB) ? cnt + 1 : cnt;
    oreq = gv ? vga_read : (gd & drq);
    if (owner == 0 || !oreq || acc) owner = (vga_read && (cn < VB || !drq)) ? 1 : drq ? 2 : 0;
    cnt = cn;
    if (acc && erd) begin
      tags.push_back(gd);
      r.due = cyc + LAT;
      r.data = $urandom;
      mem_pend.push_back(r);
    end
    last_acc = acc;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_ticks(input int n);
    vga_read = 0; drw_read = 0; drw_write = 0; mem_waitrequest = 0;
    repeat (n) tick();
  endtask
  task automatic issue(input bit port, input bit wr);
    int n;
    n = 0;
    if (port) begin
      drw_read = !wr; drw_write = wr; drw_address = AW'($urandom);
      drw_writedata = $urandom; drw_byteenable = 4'($urandom);
    end else begin
      vga_read = 1; vga_address = AW'($urandom);
    end
    do begin tick(); n++; end while (!last_acc && n < 50);
    chk("issue_accept", 32'(last_acc), 32'd1);
    vga_read = 0; drw_read = 0; drw_write = 0;
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (vga_readdatavalid | drw_readdatavalid) begin
      vga_v += int'(vga_readdatavalid);
      drw_v += int'(drw_readdatavalid);
      if (exp_q.size() == 0) chk("rdv_unexpected", {30'd0, vga_readdatavalid, drw_readdatavalid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rdv_port", {30'd0, vga_readdatavalid, drw_readdatavalid}, e.port ? 32'd1 : 32'd2);
        chk("rdv_data", e.port ? drw_readdata : vga_readdata, e.data);
      end
    end
  end
  initial begin
    int n, v0, d0, k;
    logic [AW-1:0] a;
    // reset state, with requests and a stray return present
    vga_read = 1; drw_read = 1; mem_readdatavalid = 1; mem_readdata = 32'h1234;
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_vga_wait", 32'(vga_waitrequest), 1);
    chk("rst_drw_wait", 32'(drw_waitrequest), 1);
    chk("rst_vga_rdv", 32'(vga_readdatavalid), 0);
    chk("rst_drw_rdv", 32'(drw_readdatavalid), 0);
    @(posedge clk); #1;
    reset = 1; vga_read = 0; drw_read = 0; mem_readdatavalid = 0; ret_en = 1;
    // 1: VGA only, 20 back-to-back reads
    v0 = vga_v; d0 = drw_v; n = 0;
    vga_read = 1;
    repeat (21) begin vga_address = AW'($urandom); tick(); n += int'(last_vacc); end
    idle_ticks(10);
    chk("t1_accepts", n, 20);
    chk("t1_vga_rdv", vga_v - v0, 20);
    chk("t1_drw_rdv", drw_v - d0, 0);
    // 2: both requesting continuously -> 16 VGA, 1 draw, repeat
    vga_read = 1; drw_read = 1;
    tick();
    for (int i = 0; i < 34; i++) begin
      vga_address = AW'($urandom); drw_address = AW'($urandom);
      tick();
      chk("t2_seq", {30'd0, last_vacc, last_dacc}, (i % 17 == 16) ? 32'd1 : 32'd2);
    end
    idle_ticks(10);
    // 3: interleaved VGA, DRW, VGA reads
    v0 = vga_v; d0 = drw_v;
    issue(0, 0); issue(1, 0); issue(0, 0);
    idle_ticks(10);
    chk("t3_vga_rdv", vga_v - v0, 2);
    chk("t3_drw_rdv", drw_v - d0, 1);
    // 4: tag FIFO full blocks reads, not writes
    ret_en = 0;
    repeat (MAXP) issue(1, 0);
    drw_read = 1;
    repeat (3) tick();
    chk("t4_blk_read", 32'(mem_read), 0);
    chk("t4_blk_wait", 32'(drw_waitrequest), 1);
    issue(1, 1);
    drw_read = 1;
    tick();
    chk("t4_still_blk", 32'(last_acc), 0);
    ret_en = 1;
    tick();
    tick();
    chk("t4_after_ret", 32'(last_acc), 1);
    idle_ticks(20);
    // 5: stalled VGA read keeps the grant while draw waits
    a = AW'($urandom);
    vga_read = 1; vga_address = a; drw_write = 1; drw_writedata = $urandom; drw_byteenable = 4'hA;
    tick();
    mem_waitrequest = 1;
    repeat (5) begin
      tick();
      chk("t5_addr", 32'(mem_address), 32'(a));
      chk("t5_drw_wait", 32'(drw_waitrequest), 1);
    end
    mem_waitrequest = 0;
    tick();
    chk("t5_accept", 32'(last_vacc), 1);
    idle_ticks(10);
    // 6: reset with 4 reads outstanding; returns during reset are dropped
    ret_en = 0;
    repeat (4) issue(0, 0);
    vga_read = 1; mem_readdatavalid = 1; mem_readdata = 32'hDEAD;
    #2 reset = 0;
    #1;
    chk("t6_mem_read", 32'(mem_read), 0);
    chk("t6_vga_wait", 32'(vga_waitrequest), 1);
    chk("t6_vga_rdv", 32'(vga_readdatavalid), 0);
    tags.delete(); owner = 0; cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1; vga_read = 0; mem_readdatavalid = 0; mem_pend.delete(); ret_en = 1;
    v0 = vga_v;
    issue(0, 0);
    idle_ticks(8);
    chk("t6_post_rdv", vga_v - v0, 1);
    // randomized traffic
    repeat (800) begin
      vga_read = $urandom_range(0, 2) != 0;
      vga_address = AW'($urandom);
      k = $urandom_range(0, 3);
      drw_read = k == 1; drw_write = k == 2;
      drw_address = AW'($urandom); drw_writedata = $urandom; drw_byteenable = 4'($urandom);
      mem_waitrequest = $urandom_range(0, 3) == 0;
      ret_en = $urandom_range(0, 4) != 0;
      tick();
    end
    ret_en = 1;
    idle_ticks(40);
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
